// File: rtl/imem_loader.sv
// imem_loader: synchronises a byte-wide host bus into clk_int, assembles multi-beat frames
// and commits them as single-cycle imem writes. Define IMEM_LOADER_CHECKSUM_EN for a checksum beat.
module imem_loader #(
   parameter int BUS_W       = 8,
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 40,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1023,
   parameter int CNT_W       = 16
) (
   input  logic              clk_int,
   input  logic              reset,
   input  logic              mode_load,
   input  logic [BUS_W-1:0]  pin_data,
   input  logic              pin_strobe,
   output logic              pin_ack,
   output logic [ADDR_W-1:0] imem_write_adr,
   output logic [DATA_W-1:0] imem_in,
   output logic              imem_write,
   output logic              busy,
   output logic              frame_error,
   output logic [CNT_W-1:0]  commit_count
);

   localparam int WORD_W = ADDR_W + DATA_W;
   localparam int BEATS  = (WORD_W + BUS_W - 1) / BUS_W;
   localparam int BC_W   = $clog2(BEATS + 1);
   localparam int TMO_W  = $clog2(TIMEOUT + 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, RECV, CSUM, WRITE} state_t;
   localparam state_t DATA_DONE = CSUM;
`else
   typedef enum logic [1:0] {IDLE, RECV, WRITE} state_t;
   localparam state_t DATA_DONE = WRITE;
`endif
   localparam logic DONE_BUSY = (DATA_DONE != WRITE);

   function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] s,
                                                  input logic [BUS_W-1:0]  b);
      return (s << BUS_W) | WORD_W'(b);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
   endfunction

   logic [BUS_W-1:0]       data_sync [SYNC_STAGES];
   logic [SYNC_STAGES-1:0] strobe_sync;
   logic                   strobe_prev;
   logic                   beat_edge;
   logic [BUS_W-1:0]       beat;

   state_t                 state;
   logic [BC_W-1:0]        beat_cnt;
   logic [TMO_W-1:0]       tmo_cnt;
   // Pad bits above the address never reach the word, so only WORD_W bits are kept.
   logic [WORD_W-1:0]      shifter;
   logic                   mode_prev;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [BUS_W-1:0]       csum;
`endif

   // Synchroniser stage: data and strobe share the same depth so a beat lines up with its edge.
   always_ff @(posedge clk_int) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
         strobe_sync <= '0;
         strobe_prev <= 1'b0;
      end else begin
         data_sync[0] <= pin_data;
         for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
         strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], pin_strobe};
         strobe_prev <= strobe_sync[SYNC_STAGES-1];
      end
   end

   assign beat_edge = strobe_sync[SYNC_STAGES-1] & ~strobe_prev;
   assign beat      = data_sync[SYNC_STAGES-1];

   // Frame assembly stage.
   always_ff @(posedge clk_int) begin
      if (reset) begin
         state          <= IDLE;
         beat_cnt       <= '0;
         tmo_cnt        <= '0;
         shifter        <= '0;
         mode_prev      <= 1'b0;
         pin_ack        <= 1'b0;
         imem_write_adr <= '0;
         imem_in        <= '0;
         imem_write     <= 1'b0;
         busy           <= 1'b0;
         frame_error    <= 1'b0;
         commit_count   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum           <= '0;
`endif
      end else begin
         mode_prev  <= mode_load;
         imem_write <= 1'b0;
         case (state)
            IDLE: begin
               beat_cnt <= '0;
               tmo_cnt  <= '0;
               if (beat_edge && mode_load) begin
                  shifter  <= shift_in(shifter, beat);
                  pin_ack  <= ~pin_ack;
                  beat_cnt <= BC_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum     <= beat;
`endif
                  if (BEATS == 1) begin
                     state <= DATA_DONE;
                     busy  <= DONE_BUSY;
                  end else begin
                     state <= RECV;
                     busy  <= 1'b1;
                  end
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            RECV, CSUM: begin
`else
            RECV: begin
`endif
               if (!mode_load) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  beat_cnt <= '0;
                  tmo_cnt  <= '0;
               end else if (beat_edge) begin
                  // A beat in the same cycle as the timeout wins and restarts the window.
                  pin_ack <= ~pin_ack;
                  tmo_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  if (state == CSUM) begin
                     busy <= 1'b0;
                     if (beat == csum) begin
                        state <= WRITE;
                     end else begin
                        state       <= IDLE;
                        frame_error <= 1'b1;
                     end
                  end else
`endif
                  begin
                     shifter  <= shift_in(shifter, beat);
                     beat_cnt <= beat_cnt + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                     csum     <= csum ^ beat;
`endif
                     if (beat_cnt == BC_W'(BEATS - 1)) begin
                        state <= DATA_DONE;
                        busy  <= DONE_BUSY;
                     end
                  end
               end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  beat_cnt    <= '0;
                  frame_error <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            WRITE: begin
               imem_write_adr <= shifter[WORD_W-1 -: ADDR_W];
               imem_in        <= shifter[DATA_W-1:0];
               imem_write     <= 1'b1;
               commit_count   <= sat_inc(commit_count);
               state          <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
         if (mode_load && !mode_prev) frame_error <= 1'b0;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader with a beat/frame-level reference model and per-cycle compare.
// Exercises the checksum path too when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

   localparam int BUS_W   = 8;
   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 40;
   localparam int S       = 2;
   localparam int TIMEOUT = 1023;
   localparam int CNT_W   = 16;
   localparam int BEATS   = (ADDR_W + DATA_W + BUS_W - 1) / BUS_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              mode_load;
   logic [BUS_W-1:0]  pin_data;
   logic              pin_strobe;
   logic              pin_ack;
   logic [ADDR_W-1:0] imem_write_adr;
   logic [DATA_W-1:0] imem_in;
   logic              imem_write;
   logic              busy;
   logic              frame_error;
   logic [CNT_W-1:0]  commit_count;

   imem_loader #(
      .BUS_W(BUS_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .SYNC_STAGES(S), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .clk_int(clk), .reset(reset), .mode_load(mode_load),
      .pin_data(pin_data), .pin_strobe(pin_strobe), .pin_ack(pin_ack),
      .imem_write_adr(imem_write_adr), .imem_in(imem_in), .imem_write(imem_write),
      .busy(busy), .frame_error(frame_error), .commit_count(commit_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: expected outputs after each clock edge.
   bit                model_live = 1'b0;
   bit                e_ack, e_wr, e_busy, e_err;
   logic [ADDR_W-1:0] e_adr;
   logic [DATA_W-1:0] e_dat;
   logic [CNT_W-1:0]  e_cnt;

   initial begin : model
      bit                sq[$];
      logic [BUS_W-1:0]  dq[$];
      logic [BUS_W-1:0]  frame_q[$];
      bit                in_frame, pend_wr, mprev;
      int                since_beat;
      bit                rise;
      logic [BUS_W-1:0]  bv, x;
      logic [63:0]       w;
      forever begin
         @(posedge clk);
         if (reset) begin
            sq.delete(); dq.delete(); frame_q.delete();
            for (int i = 0; i <= S; i++) begin sq.push_back(1'b0); dq.push_back('0); end
            in_frame = 0; pend_wr = 0; mprev = 0; since_beat = 0;
            e_ack = 0; e_wr = 0; e_busy = 0; e_err = 0; e_adr = '0; e_dat = '0; e_cnt = '0;
            model_live = 1'b1;
         end else if (model_live) begin
            // A strobe rise sampled S edges ago is seen now, with the data sampled alongside it.
            sq.push_back(pin_strobe);
            dq.push_back(pin_data);
            rise = sq[sq.size()-1-S] && !sq[sq.size()-2-S];
            bv   = dq[dq.size()-1-S];
            void'(sq.pop_front());
            void'(dq.pop_front());
            e_wr = 0;
            if (pend_wr) begin
               w = '0;
               for (int i = 0; i < BEATS; i++) w = (w << BUS_W) | 64'(frame_q[i]);
               e_adr = w[ADDR_W+DATA_W-1:DATA_W];
               e_dat = w[DATA_W-1:0];
               e_wr  = 1;
               if (e_cnt != {CNT_W{1'b1}}) e_cnt = e_cnt + 1'b1;
               pend_wr = 0;
            end else if (in_frame) begin
               if (!mode_load) begin
                  in_frame = 0;
               end else if (rise) begin
                  e_ack = ~e_ack;
                  since_beat = 0;
                  if (frame_q.size() < BEATS) begin
                     frame_q.push_back(bv);
                     if (frame_q.size() == BEATS && !CSUM_EN) begin
                        in_frame = 0; pend_wr = 1;
                     end
                  end else begin
                     x = '0;
                     foreach (frame_q[i]) x = x ^ frame_q[i];
                     if (bv == x) pend_wr = 1; else e_err = 1;
                     in_frame = 0;
                  end
               end else begin
                  since_beat++;
                  if (since_beat == TIMEOUT) begin e_err = 1; in_frame = 0; end
               end
            end else if (rise && mode_load) begin
               e_ack = ~e_ack;
               frame_q = {bv};
               since_beat = 0;
               in_frame = 1;
            end
            if (mode_load && !mprev) e_err = 0;
            mprev  = mode_load;
            e_busy = in_frame;
         end
      end
   end

   // Per-cycle compare plus simple event monitors.
   int ack_toggles = 0;
   int wr_seen     = 0;
   initial begin : compare
      logic last_ack;
      last_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (model_live) begin
            check("pin_ack", 64'(pin_ack), 64'(e_ack));
            check("imem_write", 64'(imem_write), 64'(e_wr));
            check("busy", 64'(busy), 64'(e_busy));
            check("frame_error", 64'(frame_error), 64'(e_err));
            check("imem_write_adr", 64'(imem_write_adr), 64'(e_adr));
            check("imem_in", 64'(imem_in), 64'(e_dat));
            check("commit_count", 64'(commit_count), 64'(e_cnt));
         end
         if (pin_ack !== last_ack) ack_toggles++;
         last_ack = pin_ack;
         if (imem_write === 1'b1) wr_seen++;
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   logic [BUS_W-1:0] fr [BEATS];

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_beat(input logic [BUS_W-1:0] b);
      pin_data = b;
      cyc(S + 1 + $urandom_range(0, 3));
      pin_strobe = 1'b1;
      cyc(S + 1 + $urandom_range(0, 3));
      pin_strobe = 1'b0;
   endtask

   task automatic send_frame(input int n);
      for (int i = 0; i < n; i++) send_beat(fr[i]);
   endtask

   task automatic send_full(input bit bad_csum);
      logic [BUS_W-1:0] x;
      send_frame(BEATS);
      if (CSUM_EN) begin
         x = '0;
         for (int i = 0; i < BEATS; i++) x = x ^ fr[i];
         send_beat(bad_csum ? ~x : x);
      end
   endtask

   task automatic rand_frame();
      for (int i = 0; i < BEATS; i++) fr[i] = BUS_W'($urandom);
   endtask

   initial begin : stim
      logic a;
      int   base;
      reset = 1'b1; mode_load = 1'b0; pin_strobe = 1'b0; pin_data = '0;
      cyc(3);
      check("rst_ack", 64'(pin_ack), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(frame_error), 64'd0);
      check("rst_cnt", 64'(commit_count), 64'd0);
      check("rst_adr", 64'(imem_write_adr), 64'd0);
      reset = 1'b0;
      mode_load = 1'b1;
      cyc(2);

      // Reference frame from the example.
      ack_toggles = 0; wr_seen = 0;
      fr = '{8'h00, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      send_full(1'b0);
      cyc(10);
      check("ex_adr", 64'(imem_write_adr), 64'h05A);
      check("ex_dat", 64'(imem_in), 64'h01_0203_0405);
      check("ex_model_adr", 64'(e_adr), 64'h05A);
      check("ex_model_dat", 64'(e_dat), 64'h01_0203_0405);
      check("ex_cnt", 64'(commit_count), 64'd1);
      check("ex_acks", 64'(ack_toggles), 64'(BEATS + int'(CSUM_EN)));
      check("ex_writes", 64'(wr_seen), 64'd1);

      // Stall mid-frame until timeout.
      rand_frame();
      send_frame(3);
      cyc(TIMEOUT + 20);
      check("tmo_err", 64'(frame_error), 64'd1);
      check("tmo_busy", 64'(busy), 64'd0);
      check("tmo_cnt", 64'(commit_count), 64'd1);
      rand_frame();
      send_full(1'b0);
      cyc(10);
      check("post_tmo_cnt", 64'(commit_count), 64'd2);
      check("post_tmo_err", 64'(frame_error), 64'd1);
      mode_load = 1'b0; cyc(3);
      mode_load = 1'b1; cyc(3);
      check("err_clear", 64'(frame_error), 64'd0);

      // mode_load dropped mid-frame, then strobes while unloaded.
      rand_frame();
      send_frame(4);
      cyc(2);
      mode_load = 1'b0;
      cyc(3);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_err", 64'(frame_error), 64'd0);
      check("abort_cnt", 64'(commit_count), 64'd2);
      a = pin_ack;
      send_beat(8'hA5);
      send_beat(8'h3C);
      cyc(6);
      check("unload_ack", 64'(pin_ack), 64'(a));
      mode_load = 1'b1;
      cyc(3);

      // Reset mid-frame.
      rand_frame();
      send_frame(5);
      reset = 1'b1;
      cyc(2);
      check("mid_rst_ack", 64'(pin_ack), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_cnt", 64'(commit_count), 64'd0);
      check("mid_rst_dat", 64'(imem_in), 64'd0);
      reset = 1'b0;
      cyc(2);
      rand_frame();
      send_full(1'b0);
      cyc(10);
      check("after_rst_cnt", 64'(commit_count), 64'd1);
      check("after_rst_adr", 64'(imem_write_adr), 64'({fr[0][1:0], fr[1]}));
      check("after_rst_dat", 64'(imem_in), 64'({fr[2], fr[3], fr[4], fr[5], fr[6]}));

      // Randomised back-to-back frames.
      base = int'(commit_count);
      for (int k = 0; k < 15; k++) begin
         rand_frame();
         send_full(1'b0);
         cyc($urandom_range(1, 8));
      end
      cyc(6);
      check("rand_cnt", 64'(commit_count), 64'(base + 15));

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Example frame with a wrong checksum beat.
      base = int'(commit_count);
      fr = '{8'h00, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      send_frame(BEATS);
      send_beat(8'h00);
      cyc(10);
      check("bad_csum_err", 64'(frame_error), 64'd1);
      check("bad_csum_cnt", 64'(commit_count), 64'(base));
`endif

      cyc(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
